mem_access_ctl: RTL

Memory-stage access controller. It consumes the memory-target enables, write enable and address/data fields that the EX/MEM pipeline register presents, and turns each memory instruction into a single valid/ready transaction on the shared memory I/O bus. It stalls the pipeline until the transaction completes and returns read data to the MEM/WB path. It is the responder end of the EX/MEM memory-control signals: one bus transaction per memory instruction, with a bounded wait.

---
 rtl/mem_access_ctl_if.sv | 22 ++
 rtl/mem_access_ctl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctl_if.sv
// Memory I/O bus between the MEM-stage access controller (master) and the memory side (slave).
// One valid/ready request per instruction, then an optional read response.
interface mem_access_ctl_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_target;
   logic        req_wen;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_data;

   modport master (
      output req_valid, req_target, req_wen, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_target, req_wen, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mem_access_ctl.sv
// MEM-stage access controller: turns each EX/MEM memory instruction into one bus transaction,
// stalls the pipeline until it completes or times out, and returns read data.
module mem_access_ctl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clock,
   input  logic               nreset,
   input  logic               mem_wen,
   input  logic               main_memory_enable,
   input  logic               frame_buffer_enable,
   input  logic               call_stack_enable,
   input  logic               prog_mem_enable,
   input  logic [15:0]        addr_in,
   input  logic [7:0]         wdata_in,
   input  logic [13:0]        call_addr_in,
   mem_access_ctl_if.master   bus,
   output logic               stall,
   output logic [15:0]        rdata_out,
   output logic               rdata_valid,
   input  logic               err_clr,
   output logic               timeout_err,
   output logic               multi_sel_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        req_valid_q;
   logic [1:0]  target_q;
   logic        wen_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic        rdata_valid_q;
   logic        timeout_err_q;
   logic        multi_sel_err_q;

   logic        any_en;
   logic        multi_sel;
   logic        timeout_hit;
   logic [1:0]  target_d;
   logic [15:0] addr_d;
   logic [15:0] wdata_d;

   assign any_en = call_stack_enable | prog_mem_enable | main_memory_enable | frame_buffer_enable;
   assign multi_sel = (call_stack_enable  & (prog_mem_enable | main_memory_enable | frame_buffer_enable))
                    | (prog_mem_enable    & (main_memory_enable | frame_buffer_enable))
                    | (main_memory_enable & frame_buffer_enable);
   assign timeout_hit = (cnt_q == TO_LAST);

   always_comb begin
      target_d = 2'd0;
      addr_d   = addr_in;
      wdata_d  = {8'h00, wdata_in};
      if (call_stack_enable) begin
         // The call stack is addressed by its own pointer, so the bus address is zeroed.
         target_d = 2'd2;
         addr_d   = '0;
         if (mem_wen) begin
            wdata_d = {2'b00, call_addr_in};
         end
      end else if (prog_mem_enable) begin
         target_d = 2'd3;
      end else if (main_memory_enable) begin
         target_d = 2'd0;
      end else if (frame_buffer_enable) begin
         target_d = 2'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         req_valid_q     <= 1'b0;
         target_q        <= '0;
         wen_q           <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         rdata_q         <= '0;
         rdata_valid_q   <= 1'b0;
         timeout_err_q   <= 1'b0;
         multi_sel_err_q <= 1'b0;
      end else begin
         rdata_valid_q <= 1'b0;
         // Clear first so that a same-cycle error event below overrides it.
         if (err_clr) begin
            timeout_err_q   <= 1'b0;
            multi_sel_err_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (any_en) begin
                  target_q    <= target_d;
                  wen_q       <= mem_wen;
                  addr_q      <= addr_d;
                  wdata_q     <= wdata_d;
                  req_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= REQ;
                  if (multi_sel) begin
                     multi_sel_err_q <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (bus.req_ready) begin
                  req_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= wen_q ? DONE : WAIT_RSP;
               end else if (timeout_hit) begin
                  req_valid_q   <= 1'b0;
                  timeout_err_q <= 1'b1;
                  if (!wen_q) begin
                     rdata_q       <= 16'hFFFF;
                     rdata_valid_q <= 1'b1;
                  end
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            WAIT_RSP: begin
               if (bus.rsp_valid) begin
                  rdata_q       <= bus.rsp_data;
                  rdata_valid_q <= 1'b1;
                  state_q       <= DONE;
               end else if (timeout_hit) begin
                  timeout_err_q <= 1'b1;
                  rdata_q       <= 16'hFFFF;
                  rdata_valid_q <= 1'b1;
                  state_q       <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign stall = ((state_q == IDLE) & any_en) | (state_q == REQ) | (state_q == WAIT_RSP);

   assign bus.req_valid  = req_valid_q;
   assign bus.req_target = target_q;
   assign bus.req_wen    = wen_q;
   assign bus.req_addr   = addr_q;
   assign bus.req_wdata  = wdata_q;

   assign rdata_out     = rdata_q;
   assign rdata_valid   = rdata_valid_q;
   assign timeout_err   = timeout_err_q;
   assign multi_sel_err = multi_sel_err_q;

endmodule
